uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Downstream consumer of the CPU's output port: it captures each byte strobed by the CPU's tx_en/output_register pair and serialises it as 8N1 UART on a single pin.
A small synchronous FIFO absorbs bursts, because OUT instructions can be issued faster than one byte per UART frame.
Sits between the CPU core and the top-level uo_out tx pin.

Parameters:
CLK_DIV, 87, clock cycles per UART bit (87 ≈ 115200 baud at 10 MHz); minimum 2
FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
data_in  in  8  byte to transmit (CPU output register value)
data_valid  in  1  single-cycle write strobe (CPU tx_en)
tx  out  1  serial line, idle high
busy  out  1  high while a frame is in flight or FIFO non-empty
full  out  1  FIFO holds FIFO_DEPTH entries
overflow  out  1  sticky: a strobe was dropped because FIFO was full

Behaviour:
- Reset values: tx=1, busy=0, full=0, overflow=0; FIFO pointers/count=0, state=IDLE, baud_cnt=0, bit_idx=0.
- Reset asserted mid-frame: all of the above take effect on the next edge and FIFO contents are discarded.
- FIFO push:
  - Push on data_valid && !full, using registered full.
  - A strobe while full is dropped even if a pop occurs in the same cycle, and sets overflow (cleared only by reset).
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - tx=1.
  - If FIFO non-empty: pop head into shift register, tx<=0, baud_cnt<=0, go START.
- START: tx held 0 for exactly CLK_DIV cycles. At baud_cnt==CLK_DIV-1: tx<=shift[0], bit_idx<=0, go DATA.
- DATA:
  - Each bit is held CLK_DIV cycles, LSB first.
  - At bit end: if bit_idx==7 then tx<=1 and go STOP; else shift right, bit_idx+1, tx<=next bit.
- STOP:
  - tx=1 for CLK_DIV cycles.
  - At end: if FIFO non-empty, pop, tx<=0, go START (no idle gap between frames); else go IDLE.
- baud_cnt: counts 0..CLK_DIV-1 and wraps to 0 on every bit boundary.
- Latency: data_valid sampled at edge k with FSM idle and FIFO empty → tx low after edge k+1 (2 clocks).
- Frame length: 10·CLK_DIV cycles.
- busy = (state!=IDLE) || FIFO non-empty; registered.
- full = (count==FIFO_DEPTH).
- Pointer width is log2(FIFO_DEPTH); pointers wrap naturally. count is one bit wider than the pointers.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame becomes 11·CLK_DIV cycles (8E1).
- Undefined: no PARITY state and no parity logic; 8N1 as above.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, PARITY)
  - UART_DATA_BITS=8
  - UART_IDLE_LEVEL=1'b1
- Sub-module uart_sync_fifo:
  - parameter DEPTH
  - ports clk, reset, push, push_data, pop, pop_data, full, empty
  - Instantiated once.
- FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
1. CLK_DIV=4, strobe 0xA5 once → tx low 2 clocks after strobe for 4 cycles; then data bits 1,0,1,0,0,1,0,1 (4 cycles each); then stop high 4 cycles; busy falls after the 40th frame cycle.
2. Strobes 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames, 120 cycles total, no idle gap between them, decoded bytes match in order.
3. FIFO_DEPTH=4, six strobes on consecutive cycles while idle → bytes 0–4 transmitted; byte 5 dropped; full=1 at the 6th strobe; overflow=1 and stays 1 after all frames finish.
4. Reset asserted during data bit 3 of a frame with 2 bytes queued → next edge: tx=1, busy=0, full=0, overflow=0; no further falling edge on tx.
5. UART_TX_PARITY_EN defined, strobe 0x07 → parity bit 1, frame 44 cycles. Strobe 0x03 → parity bit 0.
6. Strobe 0x00 then 0xFF → data bits all 0 then all 1; stop bits high; no glitch on tx at bit boundaries.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and line constants for the UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY
   } uart_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous byte FIFO
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [UART_DATA_BITS-1:0] push_data,
   input  logic                      pop,
   output logic [UART_DATA_BITS-1:0] pop_data,
   output logic                      full,
   output logic                      empty
);

   localparam int PW = $clog2(DEPTH);

   logic [UART_DATA_BITS-1:0] mem [DEPTH];
   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             rd_ptr;
   logic [PW:0]               count;
   logic                      do_push;
   logic                      do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == (PW + 1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter for the CPU output port
// Defining UART_TX_PARITY_EN adds an even parity bit (8E1).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 87,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       tx,
   output logic       busy,
   output logic       full,
   output logic       overflow
);

   localparam int                BW        = $clog2(CLK_DIV);
   localparam int                IW        = $clog2(UART_DATA_BITS);
   localparam logic [BW-1:0]     BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [IW-1:0]     LAST_BIT  = IW'(UART_DATA_BITS - 1);

   uart_state_t               state;
   uart_state_t               state_n;
   logic [BW-1:0]             baud_cnt;
   logic [BW-1:0]             baud_n;
   logic [IW-1:0]             bit_idx;
   logic [IW-1:0]             bit_idx_n;
   logic [UART_DATA_BITS-1:0] shift;
   logic [UART_DATA_BITS-1:0] shift_n;
   logic [UART_DATA_BITS-1:0] pop_data;
   logic                      tx_n;
   logic                      busy_n;
   logic                      push;
   logic                      pop;
   logic                      empty;
   logic                      bit_end;

`ifdef UART_TX_PARITY_EN
   logic                      parity;
`endif

   // full is the registered FIFO flag, so a strobe is dropped even if a pop lands the same cycle.
   assign push    = data_valid && !full;
   assign bit_end = (baud_cnt == BAUD_LAST);

   uart_sync_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(data_in),
      .pop      (pop),
      .pop_data (pop_data),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      state_n   = state;
      baud_n    = baud_cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      tx_n      = tx;
      pop       = 1'b0;

      if (state != IDLE) begin
         baud_n = bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            tx_n   = UART_IDLE_LEVEL;
            baud_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = pop_data;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_n      = shift[0];
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  tx_n    = parity;
                  state_n = PARITY;
`else
                  tx_n    = UART_IDLE_LEVEL;
                  state_n = STOP;
`endif
               end else begin
                  shift_n   = shift >> 1;
                  bit_idx_n = bit_idx + 1'b1;
                  tx_n      = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               tx_n    = UART_IDLE_LEVEL;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = pop_data;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  tx_n    = UART_IDLE_LEVEL;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            tx_n    = UART_IDLE_LEVEL;
            state_n = IDLE;
         end
      endcase

      // Going idle never coincides with a pop, so the FIFO empties next cycle only if nothing is pushed.
      busy_n = (state_n != IDLE) || !empty || push;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= UART_IDLE_LEVEL;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
         tx       <= tx_n;
         busy     <= busy_n;
         if (data_valid && full) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         parity <= 1'b0;
      end else if (pop) begin
         parity <= ^pop_data;
      end
   end
`endif

endmodule
